// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage
//
// Request buffer and result register wrapped around an external combinational
// 32-bit ALU. Decode pushes {a, b, op} requests through a valid/ready
// handshake into a small FIFO. The FIFO head is presented to the ALU, and the
// ALU result is captured into a single output slot that writeback drains
// through its own valid/ready handshake.
//
// Parameters
//   W      operand/result width
//   DEPTH  FIFO entries (power of 2, >= 2)
//
// Ports
//   clk, rst             rising-edge clock, synchronous active-high reset
//   in_valid/in_ready    request handshake from decode
//   in_a, in_b, in_op    request operands (signed) and op code
//                        (000 and, 001 or, 010 add, 110 sub, 111 slt)
//   alu_a, alu_b, alu_op FIFO head driven to the ALU (zero when empty)
//   alu_z, alu_ex        combinational ALU result and zero/ex flag
//   out_valid/out_ready  result handshake towards writeback
//   out_z, out_ex        registered result and flag
//   out_err              registered result came from an illegal op
//   count                FIFO occupancy
//   err_cnt              number of illegal ops issued, saturating at 255
// ---------------------------------------------------------------------------
module alu_issue_stage #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,

    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [W-1:0]                 in_a,
    input  logic [W-1:0]                 in_b,
    input  logic [2:0]                   in_op,

    output logic [W-1:0]                 alu_a,
    output logic [W-1:0]                 alu_b,
    output logic [2:0]                   alu_op,
    input  logic [W-1:0]                 alu_z,
    input  logic                         alu_ex,

    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [W-1:0]                 out_z,
    output logic                         out_ex,
    output logic                         out_err,

    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [7:0]                   err_cnt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [AW-1:0] LAST_SLOT  = AW'(DEPTH - 1);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    // FIFO storage, kept as three parallel arrays so each field maps
    // directly onto its ALU input.
    logic [W-1:0]  mem_a  [DEPTH];
    logic [W-1:0]  mem_b  [DEPTH];
    logic [2:0]    mem_op [DEPTH];

    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    logic          fifo_empty;
    logic          push;
    logic          load;
    logic          head_illegal;
    logic          err_sat;

    // Pointers wrap explicitly at the last slot instead of relying on
    // natural binary overflow, so the wrap point is obvious when reading.
    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        next_ptr = (p == LAST_SLOT) ? '0 : p + AW'(1);
    endfunction

    // Only the five documented op codes are legal; 011, 100 and 101 are
    // reported through out_err instead of being trusted to the ALU.
    function automatic logic is_legal(input logic [2:0] op);
        is_legal = (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
                   (op == OP_SUB) || (op == OP_SLT);
    endfunction

    // Handshake decisions. in_ready looks only at the current occupancy, so
    // a full FIFO refuses a request even in a cycle where it also pops; this
    // keeps in_ready free of any path from out_ready.
    always_comb begin
        fifo_empty   = (count == '0);
        in_ready     = (count != FULL_COUNT);
        push         = in_valid & in_ready;
        load         = ~fifo_empty & (~out_valid | out_ready);
        head_illegal = ~is_legal(alu_op);
        err_sat      = (err_cnt == 8'hFF);
    end

    // The ALU sees the FIFO head; an empty FIFO presents all zeros so the
    // ALU inputs never show stale data from an already-issued entry.
    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = OP_AND;
        if (!fifo_empty) begin
            alu_a  = mem_a[rd_ptr];
            alu_b  = mem_b[rd_ptr];
            alu_op = mem_op[rd_ptr];
        end
    end

    // FIFO payload writes. The contents need no reset: the pointers and
    // count alone decide what is valid, so clearing them discards the data.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr]  <= in_a;
            mem_b[wr_ptr]  <= in_b;
            mem_op[wr_ptr] <= in_op;
        end
    end

    // Pointer and occupancy bookkeeping. A simultaneous push and pop moves
    // both pointers and leaves the count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (load) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            unique case ({push, load})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Output slot. A new result is captured whenever the slot is empty or
    // is being drained this very cycle, which gives one result per cycle
    // while writeback keeps out_ready high. A stalled slot is left untouched
    // so its payload holds stable until it is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_z     <= '0;
            out_ex    <= 1'b0;
            out_err   <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            if (head_illegal) begin
                out_z   <= '0;
                out_ex  <= 1'b1;
                out_err <= 1'b1;
            end else begin
                out_z   <= alu_z;
                out_ex  <= alu_ex;
                out_err <= 1'b0;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Illegal-op counter. It counts issues (loads), not arrivals, and
    // sticks at 255 rather than wrapping back to a misleading small value.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (load && head_illegal && !err_sat) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_stage
//
// Bench for alu_issue_stage. A combinational ALU stand-in drives alu_z and
// alu_ex from the stage's ALU outputs. A queue-based model of the stage
// (pending requests plus one result slot) is advanced on every rising edge
// and compared against the DUT on every falling edge. Directed scenarios
// also pin a set of hand-computed literal results.
// ---------------------------------------------------------------------------
module tb_alu_issue_stage;

    localparam int W     = 32;
    localparam int DEPTH = 4;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic [2:0]    in_op;
    logic [W-1:0]  alu_a;
    logic [W-1:0]  alu_b;
    logic [2:0]    alu_op;
    logic [W-1:0]  alu_z;
    logic          alu_ex;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_z;
    logic          out_ex;
    logic          out_err;
    logic [2:0]    count;
    logic [7:0]    err_cnt;

    int nChecks = 0;
    int nFails  = 0;

    alu_issue_stage #(.W(W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_z     (alu_z),
        .alu_ex    (alu_ex),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_z     (out_z),
        .out_ex    (out_ex),
        .out_err   (out_err),
        .count     (count),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: and, or, wrapping add/sub, signed set-less-than.
    function automatic logic [31:0] aluFn(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
        case (op)
            3'b000:  aluFn = a & b;
            3'b001:  aluFn = a | b;
            3'b010:  aluFn = a + b;
            3'b110:  aluFn = a - b;
            3'b111:  aluFn = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: aluFn = 32'd0;
        endcase
    endfunction

    function automatic bit isIllegal(input logic [2:0] op);
        isIllegal = (op == 3'b011) || (op == 3'b100) || (op == 3'b101);
    endfunction

    // ALU stand-in; the zero flag is the ex output.
    assign alu_z  = aluFn(alu_a, alu_b, alu_op);
    assign alu_ex = (alu_z == 32'd0);

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
    } req_t;

    typedef struct packed {
        logic [31:0] z;
        logic        ex;
        logic        err;
    } res_t;

    req_t mQ[$];
    bit   mSlotValid;
    res_t mSlot;
    int   mErr;
    bit   mLive = 1'b0;
    bit   mPush;
    bit   mLoad;
    req_t mHead;

    // Model: pending requests wait in a queue; a single result slot is
    // refilled from the queue whenever it is empty or being taken.
    always @(posedge clk) begin
        if (rst) begin
            mQ.delete();
            mSlotValid = 1'b0;
            mSlot      = '0;
            mErr       = 0;
            mLive      = 1'b1;
        end else if (mLive) begin
            mPush = in_valid && (mQ.size() != DEPTH);
            mLoad = (mQ.size() != 0) && (!mSlotValid || out_ready);
            if (mLoad) begin
                mHead      = mQ.pop_front();
                mSlotValid = 1'b1;
                if (isIllegal(mHead.op)) begin
                    mSlot = '{z: 32'd0, ex: 1'b1, err: 1'b1};
                    if (mErr < 255) mErr = mErr + 1;
                end else begin
                    mSlot.z   = aluFn(mHead.a, mHead.b, mHead.op);
                    mSlot.ex  = (mSlot.z == 32'd0);
                    mSlot.err = 1'b0;
                end
            end else if (mSlotValid && out_ready) begin
                mSlotValid = 1'b0;
            end
            if (mPush) mQ.push_back('{a: in_a, b: in_b, op: in_op});
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (mLive) begin
            checkOutput("count", 32'(count), 32'(mQ.size()));
            checkOutput("in_ready", 32'(in_ready), 32'(mQ.size() != DEPTH));
            checkOutput("out_valid", 32'(out_valid), 32'(mSlotValid));
            checkOutput("err_cnt", 32'(err_cnt), 32'(mErr));
            if (mSlotValid) begin
                checkOutput("out_z", out_z, mSlot.z);
                checkOutput("out_ex", 32'(out_ex), 32'(mSlot.ex));
                checkOutput("out_err", 32'(out_err), 32'(mSlot.err));
            end
            if (mQ.size() != 0) begin
                checkOutput("alu_a", alu_a, mQ[0].a);
                checkOutput("alu_b", alu_b, mQ[0].b);
                checkOutput("alu_op", 32'(alu_op), 32'(mQ[0].op));
            end else begin
                checkOutput("alu_a idle", alu_a, 32'd0);
                checkOutput("alu_b idle", alu_b, 32'd0);
                checkOutput("alu_op idle", 32'(alu_op), 32'd0);
            end
        end
    end

    // Hold the given inputs across exactly one rising edge, then return
    // 1 time unit after that edge with the new state settled.
    task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [31:0] b,
                                 input logic [2:0] op, input logic r);
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_op     = op;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_op     = '0;
        out_ready = 1'b0;
        applyReset();
        applyReset();

        // Reset then idle
        checkOutput("reset count", 32'(count), 32'd0);
        checkOutput("reset in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset err_cnt", 32'(err_cnt), 32'd0);
        checkOutput("reset alu_op", 32'(alu_op), 32'd0);

        // Single add, one-edge latency from acceptance to result
        applyStimulus(1'b1, 32'd5, 32'd3, 3'b010, 1'b1);
        checkOutput("add accepted count", 32'(count), 32'd1);
        checkOutput("add not yet valid", 32'(out_valid), 32'd0);
        applyStimulus(1'b0, 32'd0, 32'd0, 3'b000, 1'b1);
        checkOutput("add out_valid", 32'(out_valid), 32'd1);
        checkOutput("add out_z", out_z, 32'd8);
        checkOutput("add out_err", 32'(out_err), 32'd0);

        // Signed slt then sub-to-zero, in order
        applyStimulus(1'b1, 32'hFFFF_FFFF, 32'd1, 3'b111, 1'b1);
        applyStimulus(1'b1, 32'd7, 32'd7, 3'b110, 1'b1);
        checkOutput("slt out_z", out_z, 32'd1);
        checkOutput("slt out_ex", 32'(out_ex), 32'd0);
        applyStimulus(1'b0, 32'd0, 32'd0, 3'b000, 1'b1);
        checkOutput("sub out_z", out_z, 32'd0);
        checkOutput("sub out_ex", 32'(out_ex), 32'd1);
        applyStimulus(1'b0, 32'd0, 32'd0, 3'b000, 1'b1);
        checkOutput("drained out_valid", 32'(out_valid), 32'd0);

        // Stalled output: 1 in slot + 4 in FIFO, then drain in order
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b1, 32'(i * 10), 32'(i), 3'b010, 1'b0);
        end
        checkOutput("full count", 32'(count), 32'd4);
        checkOutput("full in_ready", 32'(in_ready), 32'd0);
        checkOutput("full out_valid", 32'(out_valid), 32'd1);
        checkOutput("full out_z", out_z, 32'd11);
        applyStimulus(1'b1, 32'd99, 32'd1, 3'b010, 1'b0);
        checkOutput("refused count", 32'(count), 32'd4);
        checkOutput("full head alu_a", alu_a, 32'd20);
        checkOutput("stalled out_z", out_z, 32'd11);
        for (int i = 2; i <= 5; i++) begin
            applyStimulus(1'b0, 32'd0, 32'd0, 3'b000, 1'b1);
            checkOutput("drain out_valid", 32'(out_valid), 32'd1);
            checkOutput("drain out_z", out_z, 32'(i * 11));
        end
        applyStimulus(1'b0, 32'd0, 32'd0, 3'b000, 1'b1);
        checkOutput("after drain out_valid", 32'(out_valid), 32'd0);
        checkOutput("after drain count", 32'(count), 32'd0);

        // Illegal ops
        applyStimulus(1'b1, 32'd1, 32'd2, 3'b100, 1'b1);
        applyStimulus(1'b1, 32'd3, 32'd4, 3'b100, 1'b1);
        checkOutput("illegal1 out_err", 32'(out_err), 32'd1);
        checkOutput("illegal1 out_z", out_z, 32'd0);
        applyStimulus(1'b1, 32'd5, 32'd6, 3'b100, 1'b1);
        checkOutput("illegal2 out_err", 32'(out_err), 32'd1);
        checkOutput("illegal2 out_z", out_z, 32'd0);
        applyStimulus(1'b0, 32'd0, 32'd0, 3'b000, 1'b1);
        checkOutput("illegal3 out_err", 32'(out_err), 32'd1);
        checkOutput("illegal3 out_ex", 32'(out_ex), 32'd1);
        applyStimulus(1'b0, 32'd0, 32'd0, 3'b000, 1'b1);
        checkOutput("err_cnt after 3", 32'(err_cnt), 32'd3);
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b1, 32'(i), 32'(i), 3'b101, 1'b1);
        end
        applyStimulus(1'b0, 32'd0, 32'd0, 3'b000, 1'b1);
        applyStimulus(1'b0, 32'd0, 32'd0, 3'b000, 1'b1);
        checkOutput("err_cnt saturated", 32'(err_cnt), 32'd255);

        // Mid-stream reset drops everything
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1'b1, 32'(i), 32'(i), 3'b010, 1'b0);
        end
        applyReset();
        checkOutput("post-rst count", 32'(count), 32'd0);
        checkOutput("post-rst out_valid", 32'(out_valid), 32'd0);
        checkOutput("post-rst err_cnt", 32'(err_cnt), 32'd0);
        checkOutput("post-rst in_ready", 32'(in_ready), 32'd1);
        applyStimulus(1'b1, 32'd2, 32'd6, 3'b001, 1'b1);
        applyStimulus(1'b0, 32'd0, 32'd0, 3'b000, 1'b1);
        checkOutput("or out_valid", 32'(out_valid), 32'd1);
        checkOutput("or out_z", out_z, 32'd6);
        checkOutput("or out_err", 32'(out_err), 32'd0);

        // Mixed traffic with random backpressure, checked by the model
        for (int i = 0; i < 80; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), $urandom, $urandom,
                          3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 32'd0, 32'd0, 3'b000, 1'b1);
        end
        checkOutput("final count", 32'(count), 32'd0);
        checkOutput("final out_valid", 32'(out_valid), 32'd0);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
